cache_fill_arbiter: RTL
=======================

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 The block SHALL have parameter BLK_WORDS, default 8, meaning 16-bit words per cache block (power of 2).
REQ-002 The block SHALL have parameter MEM_LAT, default 4, meaning cycles from read issue to mem_valid; memory is pipelined and accepts one read per cycle.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning the asynchronous active-low reset.
REQ-005 The block SHALL have ports i_miss, input, 1 and i_miss_addr, input, 16, meaning the I-cache miss request and its byte address.
REQ-006 The block SHALL have ports d_miss, input, 1 and d_miss_addr, input, 16, meaning the D-cache miss request and its byte address.
REQ-007 The block SHALL have ports d_wr_req, input, 1, d_wr_addr, input, 16 and d_wr_data, input, 16, meaning a store write-through request.
REQ-008 The block SHALL have ports mem_en, output, 1, mem_wr, output, 1, mem_addr, output, 16 and mem_wdata, output, 16, meaning the single main-memory port.
REQ-009 The block SHALL have ports mem_rdata, input, 16 and mem_valid, input, 1, meaning read return data and its qualifier.
REQ-010 The block SHALL have ports fill_data, output, 16 and fill_word, output, log2(BLK_WORDS), meaning the block word being written into a cache.
REQ-011 The block SHALL have outputs i_data_wen, i_tag_wen, d_data_wen and d_tag_wen, each 1, meaning the cache array write enables.
REQ-012 The block SHALL have outputs i_stall and d_stall, each 1, meaning the fetch stall and the whole-pipeline stall.

Function
REQ-013 The FSM SHALL have states IDLE, WRITE, FILL_I, FILL_D and DONE.
REQ-014 Arbitration SHALL be evaluated in IDLE only, with fixed priority d_wr_req > d_miss > i_miss; a granted service SHALL never be preempted.
REQ-015 IDLE to WRITE SHALL occur on d_wr_req; in WRITE, mem_en=1, mem_wr=1, mem_addr=d_wr_addr and mem_wdata=d_wr_data for exactly one cycle, then the FSM goes to DONE.
REQ-016 IDLE to FILL_x SHALL latch base = miss_addr & ~(2*BLK_WORDS-1).
REQ-017 In FILL_x, issue_cnt SHALL drive mem_en=1, mem_wr=0 and mem_addr=base+2*issue_cnt on BLK_WORDS consecutive cycles; mem_en SHALL be 0 once issue_cnt=BLK_WORDS.
REQ-018 Each mem_valid in FILL_x SHALL pulse x_data_wen for one cycle, with fill_data=mem_rdata and fill_word=recv_cnt, then recv_cnt SHALL increment.
REQ-019 x_tag_wen SHALL pulse in the same cycle as the final (BLK_WORDS-th) x_data_wen, after which the FSM goes to DONE.
REQ-020 The fill latency from grant to tag write SHALL be MEM_LAT+BLK_WORDS-1 cycles (11 at defaults).
REQ-021 DONE SHALL last one cycle with no memory activity and then return to IDLE; a pending request SHALL be granted at the earliest in the following IDLE cycle.
REQ-022 d_stall SHALL equal (d_miss | d_wr_req) & ~(state==DONE & last service was D-side), and SHALL be combinational.
REQ-023 i_stall SHALL equal i_miss & ~(state==DONE & last service was FILL_I).
REQ-024 mem_valid outside FILL_x, or beyond BLK_WORDS responses, SHALL be ignored and no enable SHALL fire.
REQ-025 A request that drops before grant SHALL be forgotten; a request that drops after grant SHALL NOT abort the service.
REQ-026 The issue and receive counters SHALL be sized log2(BLK_WORDS)+1 bits with no wrap; base+2*k SHALL be computed modulo 2^16.

Reset
REQ-027 While rst=0 the FSM SHALL be IDLE, counters and the latched base 0, every enable and mem_* output 0, and fill_data and fill_word 0.
REQ-028 Reset asserted mid-fill SHALL abandon the fill, and in-flight memory returns arriving after rst=1 SHALL be ignored per REQ-024.

Verification
REQ-029 Scenario: i_miss with i_miss_addr=0x1236 -> reads at 0x1230..0x123E on cycles 0-7; i_data_wen words 0-7 on cycles 4-11; i_tag_wen on cycle 11; i_stall low on cycle 12.
REQ-030 Scenario: i_miss and d_miss raised in the same cycle -> FILL_D runs first and i_stall stays high throughout; FILL_I is granted 2 cycles after d_tag_wen.
REQ-031 Scenario: d_wr_req with addr=0x0040 and data=0xBEEF -> one cycle of mem_en=1, mem_wr=1, addr 0x0040, data 0xBEEF; d_stall high for 2 cycles.
REQ-032 Scenario: d_wr_req raised mid-FILL_I -> the fill completes uninterrupted and WRITE follows DONE.
REQ-033 Scenario: rst pulsed at fill cycle 6 -> all outputs 0 and stray mem_valid pulses produce no wen; a fresh miss then fills correctly.
REQ-034 Scenario: d_miss_addr=0xFFF2 -> reads at 0xFFF0..0xFFFE with no address wrap error.

Source files
------------

// File: rtl/cache_fill_arbiter_if.sv
// Main-memory port shared by I-side fills, D-side fills and store write-through.
// The arbiter drives the request side; the memory returns pipelined read data.
interface cache_fill_arbiter_if;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;

    modport master (
        output mem_en,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_valid
    );

    modport slave (
        input  mem_en,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_valid
    );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Arbitrates one pipelined memory port between store write-through, D-cache
// block fills and I-cache block fills; a granted service always runs to completion.
module cache_fill_arbiter #(
    parameter int unsigned BLK_WORDS = 8,
    parameter int unsigned MEM_LAT   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_miss,
    input  logic [15:0]                  i_miss_addr,
    input  logic                         d_miss,
    input  logic [15:0]                  d_miss_addr,
    input  logic                         d_wr_req,
    input  logic [15:0]                  d_wr_addr,
    input  logic [15:0]                  d_wr_data,
    cache_fill_arbiter_if.master         mem,
    output logic [15:0]                  fill_data,
    output logic [$clog2(BLK_WORDS)-1:0] fill_word,
    output logic                         i_data_wen,
    output logic                         i_tag_wen,
    output logic                         d_data_wen,
    output logic                         d_tag_wen,
    output logic                         i_stall,
    output logic                         d_stall
);

    localparam int unsigned WW = $clog2(BLK_WORDS);
    localparam int unsigned CW = WW + 1;
    localparam logic [15:0] BaseMask = ~16'(2 * BLK_WORDS - 1);

    if (BLK_WORDS < 2 || (BLK_WORDS & (BLK_WORDS - 1)) != 0 || MEM_LAT < 1) begin : g_param_check
        $error("cache_fill_arbiter: BLK_WORDS must be a power of 2 >= 2 and MEM_LAT >= 1");
    end

    typedef enum logic [2:0] {StIdle, StWrite, StFillI, StFillD, StDone} state_e;

    state_e          state_q;
    logic [CW-1:0]   issue_cnt_q;
    logic [CW-1:0]   recv_cnt_q;
    logic [15:0]     base_q;
    logic            svc_d_q;
    logic            mem_en_q;
    logic            mem_wr_q;
    logic [15:0]     mem_addr_q;
    logic [15:0]     mem_wdata_q;

    logic            filling;
    logic            recv_ok;
    logic            recv_last;

    assign filling   = (state_q == StFillI) || (state_q == StFillD);
    // Returns outside a fill or past the last word (e.g. in flight across a reset) are dropped.
    assign recv_ok   = filling && mem.mem_valid && !recv_cnt_q[CW-1];
    assign recv_last = (recv_cnt_q == CW'(BLK_WORDS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
            svc_d_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (d_wr_req) begin
                        state_q     <= StWrite;
                        svc_d_q     <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= d_wr_addr;
                        mem_wdata_q <= d_wr_data;
                    end else if (d_miss) begin
                        state_q     <= StFillD;
                        svc_d_q     <= 1'b1;
                        base_q      <= d_miss_addr & BaseMask;
                        mem_en_q    <= 1'b1;
                        mem_addr_q  <= d_miss_addr & BaseMask;
                        issue_cnt_q <= CW'(1);
                        recv_cnt_q  <= '0;
                    end else if (i_miss) begin
                        state_q     <= StFillI;
                        svc_d_q     <= 1'b0;
                        base_q      <= i_miss_addr & BaseMask;
                        mem_en_q    <= 1'b1;
                        mem_addr_q  <= i_miss_addr & BaseMask;
                        issue_cnt_q <= CW'(1);
                        recv_cnt_q  <= '0;
                    end
                end
                StWrite: begin
                    state_q     <= StDone;
                    mem_en_q    <= 1'b0;
                    mem_wr_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                end
                StFillI, StFillD: begin
                    // issue_cnt_q counts reads already presented; the word-0 read left with the grant.
                    if (!issue_cnt_q[CW-1]) begin
                        mem_en_q    <= 1'b1;
                        mem_addr_q  <= base_q + (16'(issue_cnt_q) << 1);
                        issue_cnt_q <= issue_cnt_q + CW'(1);
                    end else begin
                        mem_en_q   <= 1'b0;
                        mem_addr_q <= '0;
                    end
                    if (recv_ok) begin
                        recv_cnt_q <= recv_cnt_q + CW'(1);
                        if (recv_last) begin
                            state_q    <= StDone;
                            mem_en_q   <= 1'b0;
                            mem_addr_q <= '0;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem.mem_en    = mem_en_q;
    assign mem.mem_wr    = mem_wr_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign i_data_wen = recv_ok && (state_q == StFillI);
    assign d_data_wen = recv_ok && (state_q == StFillD);
    assign i_tag_wen  = i_data_wen && recv_last;
    assign d_tag_wen  = d_data_wen && recv_last;
    assign fill_data  = recv_ok ? mem.mem_rdata : '0;
    assign fill_word  = recv_ok ? recv_cnt_q[WW-1:0] : '0;

    // The DONE cycle releases only the side that was just served.
    assign d_stall = (d_miss || d_wr_req) && !((state_q == StDone) && svc_d_q);
    assign i_stall = i_miss && !((state_q == StDone) && !svc_d_q);

endmodule
